// File: rtl/fp_alu_pkg.sv
// Shared constants for the fp_alu and its arbiter: widths, op codes, FSM states.
package fp_alu_pkg;

  localparam int FP_W   = 32;
  localparam int FP_OPW = 6;

  localparam logic [FP_OPW-1:0] OP_ADD       = 6'b000000;
  localparam logic [FP_OPW-1:0] OP_SUB       = 6'b000001;
  localparam logic [FP_OPW-1:0] OP_LESSTHAN  = 6'b001100;
  localparam logic [FP_OPW-1:0] OP_EQUAL     = 6'b010100;
  localparam logic [FP_OPW-1:0] OP_LESSOREQ  = 6'b011100;
  localparam logic [FP_OPW-1:0] OP_GREATER   = 6'b100100;
  localparam logic [FP_OPW-1:0] OP_NOTEQUAL  = 6'b101100;
  localparam logic [FP_OPW-1:0] OP_GREATOREQ = 6'b110100;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CLR  = 2'd1,
    S_RUN  = 2'd2,
    S_RESP = 2'd3
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester after last_grant, with wrap.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IDW  = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last_grant,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  idx
);

  // Walk outward from last_grant+1; the first set bit wins.
  always_comb begin
    int  k;
    logic found;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    k     = 0;
    for (int i = 1; i <= NREQ; i++) begin
      k = (int'(last_grant) + i) % NREQ;
      if (!found && req[k]) begin
        found  = 1'b1;
        gnt[k] = 1'b1;
        idx    = IDW'(k);
      end
    end
  end

endmodule

// File: rtl/fp_alu_arbiter.sv
// Shares one fp_alu between NREQ requesters: round-robin grant, then
// clear -> run -> tagged response, one operation in flight at a time.
module fp_alu_arbiter
  import fp_alu_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int W       = FP_W,
  parameter int OPW     = FP_OPW,
  parameter int TIMEOUT = 16,
  localparam int IDW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  input  logic [NREQ*OPW-1:0] req_op,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [W-1:0]      rsp_result,
  output logic              rsp_err,
  output logic              busy,
  output logic [W-1:0]      alu_a,
  output logic [W-1:0]      alu_b,
  output logic [OPW-1:0]    alu_op,
  output logic              alu_ce,
  output logic              alu_sclr,
  input  logic [W-1:0]      alu_result,
  input  logic              alu_rdy
);

  localparam int CW = $clog2(TIMEOUT) + 1;

  arb_state_t      state;
  logic [IDW-1:0]  last_grant;
  logic [IDW-1:0]  id_q;
  logic [CW-1:0]   cnt;
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gidx;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr (
    .req        (req_valid),
    .last_grant (last_grant),
    .gnt        (gnt),
    .idx        (gidx)
  );

  // Grant is only offered from IDLE; it is the sole combinational output.
  assign req_ready = (state == S_IDLE) ? gnt : '0;

  // Op sequencer with all fp_alu and response outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      last_grant <= IDW'(NREQ - 1);
      id_q       <= '0;
      cnt        <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_result <= '0;
      rsp_err    <= 1'b0;
      busy       <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      alu_ce     <= 1'b0;
      alu_sclr   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (|gnt) begin
            alu_a    <= req_a[gidx*W +: W];
            alu_b    <= req_b[gidx*W +: W];
            alu_op   <= req_op[gidx*OPW +: OPW];
            id_q     <= gidx;
            alu_sclr <= 1'b1;
            busy     <= 1'b1;
            state    <= S_CLR;
          end
        end
        S_CLR: begin
          // One sclr cycle, then enable; operands already stable.
          alu_sclr <= 1'b0;
          alu_ce   <= 1'b1;
          cnt      <= '0;
          state    <= S_RUN;
        end
        S_RUN: begin
          cnt <= cnt + 1'b1;
          // rdy beats the timeout when both land on the last cycle.
          if (alu_rdy) begin
            rsp_result <= alu_result;
            rsp_err    <= 1'b0;
            rsp_id     <= id_q;
            rsp_valid  <= 1'b1;
            alu_ce     <= 1'b0;
            state      <= S_RESP;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            rsp_result <= '0;
            rsp_err    <= 1'b1;
            rsp_id     <= id_q;
            rsp_valid  <= 1'b1;
            alu_ce     <= 1'b0;
            state      <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid  <= 1'b0;
            last_grant <= rsp_id;
            busy       <= 1'b0;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_alu_arbiter.sv
// Scoreboard bench for fp_alu_arbiter with a small fp_alu stand-in whose
// rdy timing and result are chosen per directed vector.
module tb_fp_alu_arbiter;
  import fp_alu_pkg::*;

  localparam int NREQ = 2;
  localparam int W    = 32;
  localparam int OPW  = 6;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a, req_b;
  logic [NREQ*OPW-1:0] req_op;
  logic              rsp_valid, rsp_ready;
  logic [0:0]        rsp_id;
  logic [W-1:0]      rsp_result;
  logic              rsp_err, busy;
  logic [W-1:0]      alu_a, alu_b;
  logic [OPW-1:0]    alu_op;
  logic              alu_ce, alu_sclr;
  logic [W-1:0]      alu_result;
  logic              alu_rdy;

  fp_alu_arbiter #(.NREQ(NREQ), .W(W), .OPW(OPW), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_err(rsp_err),
    .busy(busy),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_ce(alu_ce), .alu_sclr(alu_sclr),
    .alu_result(alu_result), .alu_rdy(alu_rdy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // fp_alu stand-in: counts enabled cycles since sclr, rdy on cycle rdy_at.
  int          rdy_at    = -1;
  logic [31:0] model_res = '0;
  int          run_cnt   = 0;
  always @(posedge clk) begin
    if (alu_sclr) run_cnt <= 0;
    else if (alu_ce) run_cnt <= run_cnt + 1;
  end
  assign alu_rdy    = alu_ce && (run_cnt == rdy_at);
  assign alu_result = model_res;

  // Event counters sampled mid-cycle.
  int sclr_cnt = 0, ce_cnt = 0, onehot_bad = 0, rsp_seen = 0;
  int glog[$];
  always @(negedge clk) begin
    if (alu_sclr) sclr_cnt++;
    if (alu_ce) ce_cnt++;
    if (|req_ready) begin
      glog.push_back(req_ready[1] ? 1 : 0);
      if ($countones(req_ready) > 1) onehot_bad++;
    end
  end

  // Scoreboard monitor: {id, result, err} popped on each handshake.
  logic [33:0] sb[$];
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      rsp_seen++;
      if (sb.size() == 0) check("unexpected rsp", {30'd0, rsp_id, rsp_result, rsp_err}, 64'd0);
      else check("rsp id/result/err", {30'd0, rsp_id, rsp_result, rsp_err}, {30'd0, sb.pop_front()});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a single request, wait for its grant, then drop valid after the grant edge.
  task automatic do_req(input int k, input logic [31:0] a, input logic [31:0] b, input logic [5:0] op);
    int n;
    req_valid = '0;
    req_valid[k] = 1'b1;
    req_a[k*W +: W] = a;
    req_b[k*W +: W] = b;
    req_op[k*OPW +: OPW] = op;
    #1;
    n = 0;
    while (!req_ready[k] && n < 60) begin tick(); n++; end
    if (n >= 60) check("grant timeout", 64'd0, 64'd1);
    tick();
    req_valid = '0;
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    while (!rsp_valid && n < 100) begin tick(); n++; end
    if (n >= 100) check("rsp timeout", 64'd0, 64'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  function automatic logic any_out();
    return |{rsp_valid, rsp_id, rsp_result, rsp_err, busy, alu_a, alu_b,
             alu_op, alu_ce, alu_sclr, req_ready};
  endfunction

  initial begin
    int n, s0, c0, g0, bad;
    logic [33:0] snap;
    rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; req_op = '0; rsp_ready = 1'b0;
    #2;
    check("reset outputs zero", {63'd0, any_out()}, 64'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // 1: 1.0 + 2.0 = 3.0, rdy on RUN cycle 2 -> rsp at T+5
    rsp_ready = 1'b1; rdy_at = 2; model_res = 32'h40400000;
    sb.push_back({1'b0, 32'h40400000, 1'b0});
    req_valid = 2'b01; req_a[31:0] = 32'h3F800000; req_b[31:0] = 32'h40000000; req_op[5:0] = OP_ADD;
    #1;
    check("t1 first grant req0", {62'd0, req_ready}, 64'd1);
    s0 = sclr_cnt; c0 = ce_cnt;
    tick(); req_valid = '0;
    check("t1 clr cycle sclr/ce/a", {31'd0, alu_sclr, alu_ce, alu_a}, {31'd0, 1'b1, 1'b0, 32'h3F800000});
    wait_rsp(n);
    check("t1 latency", n, 4);
    check("t1 sclr pulses", sclr_cnt - s0, 1);
    check("t1 ce cycles", ce_cnt - c0, 3);
    check("t1 resp ce low", {63'd0, alu_ce}, 64'd0);
    tick();

    // 2: both requesters continuously valid after reset -> 0,1,0,1
    do_reset();
    rdy_at = 0; model_res = 32'h41200000; rsp_ready = 1'b1;
    repeat (4) ;
    sb.push_back({1'b0, 32'h41200000, 1'b0});
    sb.push_back({1'b1, 32'h41200000, 1'b0});
    sb.push_back({1'b0, 32'h41200000, 1'b0});
    sb.push_back({1'b1, 32'h41200000, 1'b0});
    g0 = glog.size(); s0 = rsp_seen;
    req_a = {32'h40800000, 32'h40800000}; req_b = {32'h40C00000, 32'h40C00000};
    req_op = {OP_ADD, OP_ADD};
    req_valid = 2'b11;
    n = 0;
    while (!(rsp_valid && rsp_seen - s0 == 3) && n < 100) begin tick(); n++; end
    if (n >= 100) check("t2 timeout", 64'd0, 64'd1);
    req_valid = '0;
    repeat (2) tick();
    check("t2 grant count", glog.size() - g0, 4);
    if (glog.size() - g0 == 4)
      check("t2 grant order", {glog[g0], glog[g0+1], glog[g0+2], glog[g0+3]}, {32'd0, 32'd1, 32'd0, 32'd1});
    check("t2 req_ready onehot", onehot_bad, 0);

    // 3: no rdy ever -> timeout after 16 RUN cycles, result forced to 0
    rdy_at = -1; model_res = 32'hDEADBEEF;
    sb.push_back({1'b0, 32'h0, 1'b1});
    c0 = ce_cnt;
    do_req(0, 32'h3F800000, 32'h3F800000, OP_EQUAL);
    wait_rsp(n);
    check("t3 latency", n, 17);
    check("t3 ce cycles", ce_cnt - c0, 16);
    check("t3 resp err/result/ce", {30'd0, rsp_err, rsp_result, alu_ce}, {30'd0, 1'b1, 32'h0, 1'b0});
    tick();

    // 4: response stalled 10 cycles with req1 pending
    rsp_ready = 1'b0; rdy_at = 1; model_res = 32'h3F800000;
    sb.push_back({1'b0, 32'h3F800000, 1'b0});
    do_req(0, 32'h40000000, 32'h3F800000, OP_SUB);
    req_valid = 2'b10; req_a[63:32] = 32'h40400000; req_b[63:32] = 32'h3F800000; req_op[11:6] = OP_ADD;
    wait_rsp(n);
    snap = {rsp_id, rsp_result, rsp_err};
    model_res = 32'h40800000;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if ({rsp_id, rsp_result, rsp_err} !== snap || !rsp_valid || req_ready != 0 || alu_sclr) bad++;
    end
    check("t4 stall stable", bad, 0);
    sb.push_back({1'b1, 32'h40800000, 1'b0});
    rsp_ready = 1'b1;
    tick();
    check("t4 req1 granted after hs", {62'd0, req_ready}, 64'd2);
    tick(); req_valid = '0;
    check("t4 clr after grant", {63'd0, alu_sclr}, 64'd1);
    wait_rsp(n);
    tick();

    // 5: async reset during RUN, then req1-only request
    rdy_at = -1;
    do_req(0, 32'h3F800000, 32'h40000000, OP_ADD);
    repeat (4) tick();
    check("t5 in run", {63'd0, alu_ce}, 64'd1);
    #3 rst_n = 1'b0;
    #1;
    check("t5 async reset outputs", {63'd0, any_out()}, 64'd0);
    tick();
    rst_n = 1'b1;
    rdy_at = 0; model_res = 32'h3F000000;
    sb.push_back({1'b1, 32'h3F000000, 1'b0});
    req_valid = 2'b10; req_a[63:32] = 32'h40A00000; req_b[63:32] = 32'h3F800000; req_op[11:6] = OP_LESSTHAN;
    #1;
    check("t5 req1 grant", {62'd0, req_ready}, 64'd2);
    tick(); req_valid = '0;
    check("t5 clr with req1 a", {31'd0, alu_sclr, alu_a}, {31'd0, 1'b1, 32'h40A00000});
    wait_rsp(n);
    tick();

    // 6: rdy on final RUN cycle wins over timeout
    rdy_at = 15; model_res = 32'h40A00000;
    sb.push_back({1'b0, 32'h40A00000, 1'b0});
    do_req(0, 32'h40000000, 32'h40400000, OP_ADD);
    wait_rsp(n);
    check("t6 latency", n, 17);
    check("t6 err low", {63'd0, rsp_err}, 64'd0);
    repeat (3) tick();

    check("scoreboard drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout: sim time %0t exceeded limit", $time);
    $fatal(1);
  end

endmodule
